// File: rtl/estimate_seq.sv
// Command sequencer for the estimate datapath: walks ini/acc/pool/norm/activ for every
// output neuron of one layer pass and packs the returned activ bits into 32-bit words.
module estimate_seq #(
    parameter int NACC_W  = 10,
    parameter int NPOOL_W = 4,
    parameter int NOUT_W  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [15:0]        w_base,
    input  logic [15:0]        m_base,
    input  logic [NACC_W-1:0]  n_acc,
    input  logic [NPOOL_W-1:0] n_pool,
    input  logic [NOUT_W-1:0]  n_out,
    input  logic [15:0]        bias,
    input  logic               in_valid,
    input  logic [31:0]        in_data,
    output logic               in_ready,
    output logic [2:0]         com,
    output logic [15:0]        addr,
    output logic [31:0]        data,
    input  logic               activ,
    output logic               out_valid,
    output logic [31:0]        out_data,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] COM_INI  = 3'd0;
    localparam logic [2:0] COM_ACC  = 3'd1;
    localparam logic [2:0] COM_POOL = 3'd2;
    localparam logic [2:0] COM_NORM = 3'd3;
    localparam logic [2:0] COM_ACTV = 3'd4;
    localparam logic [2:0] COM_NOP  = 3'd7;

    typedef enum logic [3:0] {
        S_IDLE, S_INI, S_ACC, S_POOL, S_NORM, S_ACTV, S_CAPT, S_FLUSH, S_DONE
    } state_t;

    state_t state, state_nx;

    // Configuration captured at start so the pass is immune to input changes.
    logic [15:0]        m_base_q, bias_q, wrow;
    logic [NACC_W-1:0]  n_acc_q, k;
    logic [NPOOL_W-1:0] n_pool_q, p;
    logic [NOUT_W-1:0]  n_out_q, o;

    logic [2:0]  com_d;
    logic [15:0] addr_d;
    logic [31:0] data_d;

    logic last_k, last_p, last_o, word_end, out_hs;

    assign last_k   = (k == n_acc_q - NACC_W'(1));
    assign last_p   = (p == n_pool_q - NPOOL_W'(1));
    assign last_o   = (o == n_out_q - NOUT_W'(1));
    assign word_end = (o[4:0] == 5'd31) || last_o;

    assign in_ready  = (state == S_ACC) && in_valid;
    assign out_valid = (state == S_FLUSH);
    assign out_hs    = out_valid && out_ready;
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        com_d    = COM_NOP;
        addr_d   = 16'd0;
        data_d   = 32'd0;
        case (state)
            S_IDLE:  if (start) state_nx = S_INI;
            S_INI: begin
                com_d    = COM_INI;
                data_d   = {16'd0, bias_q};
                state_nx = S_ACC;
            end
            S_ACC: begin
                if (in_valid) begin
                    com_d  = COM_ACC;
                    addr_d = wrow + 16'(k);
                    data_d = in_data;
                    if (last_k) state_nx = S_POOL;
                end
            end
            S_POOL: begin
                com_d    = COM_POOL;
                data_d   = {16'd0, bias_q};
                state_nx = last_p ? S_NORM : S_ACC;
            end
            S_NORM: begin
                com_d    = COM_NORM;
                addr_d   = m_base_q + 16'(o);
                state_nx = S_ACTV;
            end
            S_ACTV: begin
                com_d    = COM_ACTV;
                state_nx = S_CAPT;
            end
            S_CAPT:  state_nx = word_end ? S_FLUSH : S_INI;
            S_FLUSH: if (out_hs) state_nx = last_o ? S_DONE : S_INI;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            com      <= COM_NOP;
            addr     <= 16'd0;
            data     <= 32'd0;
            out_data <= 32'd0;
            m_base_q <= 16'd0;
            bias_q   <= 16'd0;
            wrow     <= 16'd0;
            n_acc_q  <= '0;
            n_pool_q <= '0;
            n_out_q  <= '0;
            k        <= '0;
            p        <= '0;
            o        <= '0;
        end else begin
            state <= state_nx;
            com   <= com_d;
            addr  <= addr_d;
            data  <= data_d;
            case (state)
                S_IDLE: if (start) begin
                    m_base_q <= m_base;
                    bias_q   <= bias;
                    wrow     <= w_base;
                    n_acc_q  <= n_acc;
                    n_pool_q <= n_pool;
                    n_out_q  <= n_out;
                    o        <= '0;
                    out_data <= 32'd0;
                end
                S_INI: begin
                    k <= '0;
                    p <= '0;
                end
                S_ACC:  if (in_valid) k <= k + NACC_W'(1);
                S_POOL: begin
                    k <= '0;
                    if (!last_p) p <= p + NPOOL_W'(1);
                end
                S_CAPT: begin
                    out_data[o[4:0]] <= activ;
                    if (!word_end) begin
                        o    <= o + NOUT_W'(1);
                        wrow <= wrow + 16'(n_acc_q);
                    end
                end
                S_FLUSH: if (out_hs) begin
                    out_data <= 32'd0;
                    if (!last_o) begin
                        o    <= o + NOUT_W'(1);
                        wrow <= wrow + 16'(n_acc_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_estimate_seq.sv
// Directed bench for estimate_seq: cycle-exact single-neuron pass, multi-window addressing,
// input stalls, output back-pressure, word packing with address wrap, and mid-pass reset.
module tb_estimate_seq;

    localparam int NACC_W  = 10;
    localparam int NPOOL_W = 4;
    localparam int NOUT_W  = 10;

    logic               clk = 1'b0;
    logic               reset, start;
    logic [15:0]        w_base, m_base, bias;
    logic [NACC_W-1:0]  n_acc;
    logic [NPOOL_W-1:0] n_pool;
    logic [NOUT_W-1:0]  n_out;
    logic               in_valid, in_ready;
    logic [31:0]        in_data;
    logic [2:0]         com;
    logic [15:0]        addr;
    logic [31:0]        data;
    logic               activ;
    logic               out_valid, out_ready;
    logic [31:0]        out_data;
    logic               busy, done;

    estimate_seq #(.NACC_W(NACC_W), .NPOOL_W(NPOOL_W), .NOUT_W(NOUT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .w_base(w_base), .m_base(m_base),
        .n_acc(n_acc), .n_pool(n_pool), .n_out(n_out), .bias(bias),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .com(com), .addr(addr), .data(data), .activ(activ),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Per-pass observations gathered by run_pass.
    int unsigned acc_addr[$];
    int unsigned norm_addr[$];
    logic [31:0] words[$];
    int n_ini, n_poolc, n_bubbles, n_inready, n_hold, n_act;
    int data_err, zero_err, rdy_err, hold_err, busy_err, com_err;
    bit done_seen;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Steps a pass until done, acting as feature source, estimate block and result sink.
    // activ for neuron i is 1 when i is even; feature beat b carries 0xC0DE0000|b.
    task automatic run_pass(input int max_cycles, input int stall_at, input int stall_len,
                            input int hold_len);
        int beat = 0;
        bit holding = 1'b0;
        logic [31:0] held = '0;
        acc_addr.delete(); norm_addr.delete(); words.delete();
        n_ini = 0; n_poolc = 0; n_bubbles = 0; n_inready = 0; n_hold = 0; n_act = 0;
        data_err = 0; zero_err = 0; rdy_err = 0; hold_err = 0; busy_err = 0; com_err = 0;
        done_seen = 1'b0;
        activ = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            tick();
            case (com)
                3'd0: begin
                    n_ini++;
                    if (data !== {16'd0, bias} || addr !== 16'd0) data_err++;
                end
                3'd1: begin
                    acc_addr.push_back(int'(addr));
                    if (data !== (32'hC0DE_0000 | (acc_addr.size() - 1))) data_err++;
                end
                3'd2: begin
                    n_poolc++;
                    if (data !== {16'd0, bias} || addr !== 16'd0) data_err++;
                end
                3'd3: begin
                    norm_addr.push_back(int'(addr));
                    if (data !== 32'd0) zero_err++;
                end
                3'd4: begin
                    activ = (n_act % 2 == 0);
                    n_act++;
                    if (data !== 32'd0 || addr !== 16'd0) zero_err++;
                end
                3'd7: begin
                    if (acc_addr.size() > 0 && n_poolc == 0) n_bubbles++;
                    if (data !== 32'd0 || addr !== 16'd0) zero_err++;
                end
                default: com_err++;
            endcase
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            if (!busy) busy_err++;
            if (stall_len > 0 && beat == stall_at) begin
                in_valid = 1'b0;
                stall_len--;
            end else begin
                in_valid = 1'b1;
            end
            in_data = 32'hC0DE_0000 | beat;
            if (out_valid && hold_len > 0) begin
                out_ready = 1'b0;
                if (!holding) begin
                    held    = out_data;
                    holding = 1'b1;
                end else if (out_data !== held) begin
                    hold_err++;
                end
                if (com !== 3'd7) hold_err++;
                hold_len--;
                n_hold++;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (in_ready && !in_valid) rdy_err++;
            if (out_valid && !out_ready && in_ready) hold_err++;
            if (in_ready) begin
                beat++;
                n_inready++;
            end
            if (out_valid && out_ready) words.push_back(out_data);
        end
        check("pass_done", 32'(done_seen), 32'd1);
        check("pass_com_valid", 32'(com_err), 32'd0);
        check("pass_busy", 32'(busy_err), 32'd0);
    endtask

    initial begin
        int unsigned addr_bad;
        reset = 1'b1; start = 1'b0; w_base = '0; m_base = '0; bias = '0;
        n_acc = '0; n_pool = '0; n_out = '0; in_valid = 1'b0; in_data = '0;
        activ = 1'b0; out_ready = 1'b0;
        tick(); tick();
        check("rst_com", 32'(com), 32'd7);
        check("rst_addr_data", {addr, data[15:0]}, 32'd0);
        check("rst_flags", {28'd0, in_ready, out_valid, busy, done}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        reset = 1'b0;

        // Single neuron, single beat: com 0..4 on consecutive cycles.
        w_base = 16'd0; m_base = 16'd17248; bias = 16'hFEE0;
        n_acc = 10'd1; n_pool = 4'd1; n_out = 10'd1;
        in_valid = 1'b1; in_data = 32'hA5A5_0F0F;
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ini_idle_com", 32'(com), 32'd7);
        tick();
        check("t1_com0", {13'd0, com, data[15:0]}, {13'd0, 3'd0, 16'hFEE0});
        check("t1_in_ready_acc", 32'(in_ready), 32'd1);
        tick();
        check("t1_com1", {13'd0, com, addr}, {13'd0, 3'd1, 16'd0});
        check("t1_acc_data", data, 32'hA5A5_0F0F);
        check("t1_in_ready_pool", 32'(in_ready), 32'd0);
        tick();
        check("t1_com2", data, 32'h0000_FEE0);
        check("t1_com2_code", 32'(com), 32'd2);
        tick();
        check("t1_com3", {13'd0, com, addr}, {13'd0, 3'd3, 16'd17248});
        tick();
        check("t1_com4", {13'd0, com, addr}, {13'd0, 3'd4, 16'd0});
        activ = 1'b1;
        tick();
        check("t1_capt_com", 32'(com), 32'd7);
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_data", out_data, 32'd1);
        out_ready = 1'b1;
        tick();
        check("t1_done", {29'd0, done, busy, out_valid}, 32'b100);
        check("t1_out_cleared", out_data, 32'd0);
        tick();
        check("t1_done_pulse", 32'(done), 32'd0);
        out_ready = 1'b0; activ = 1'b0;

        // Three beats, four windows, two neurons; config changed and start held after acceptance.
        w_base = 16'd0; m_base = 16'd17248; bias = 16'h0005;
        n_acc = 10'd3; n_pool = 4'd4; n_out = 10'd2;
        start = 1'b1;
        tick();
        w_base = 16'h1234; m_base = 16'd9; n_acc = 10'd7;
        run_pass(400, -1, 0, 0);
        start = 1'b0;
        addr_bad = 0;
        for (int i = 0; i < acc_addr.size() && i < 24; i++)
            if (acc_addr[i] != 3 * (i / 12) + (i % 3)) addr_bad++;
        check("t2_acc_count", acc_addr.size(), 32'd24);
        check("t2_acc_addrs", addr_bad, 32'd0);
        check("t2_ini_pool", {n_ini[15:0], n_poolc[15:0]}, {16'd2, 16'd8});
        check("t2_norm_count", norm_addr.size(), 32'd2);
        if (norm_addr.size() == 2) begin
            check("t2_norm0", norm_addr[0], 32'd17248);
            check("t2_norm1", norm_addr[1], 32'd17249);
        end
        check("t2_in_ready_beats", n_inready, 32'd24);
        check("t2_data", data_err, 32'd0);
        check("t2_word_count", words.size(), 32'd1);
        if (words.size() == 1) check("t2_word", words[0], 32'h0000_0001);
        tick();

        // Two-cycle in_valid gap mid-ACC.
        w_base = 16'd100; m_base = 16'd500; bias = 16'h7FFF;
        n_acc = 10'd4; n_pool = 4'd1; n_out = 10'd1;
        pulse_start();
        run_pass(100, 2, 2, 0);
        check("t3_acc_count", acc_addr.size(), 32'd4);
        addr_bad = 0;
        for (int i = 0; i < acc_addr.size(); i++)
            if (acc_addr[i] != 100 + i) addr_bad++;
        check("t3_acc_addrs", addr_bad, 32'd0);
        check("t3_bubbles", n_bubbles, 32'd2);
        check("t3_in_ready_track", rdy_err, 32'd0);
        check("t3_in_ready_beats", n_inready, 32'd4);
        check("t3_data", data_err + zero_err, 32'd0);
        tick();

        // Back-pressure for five cycles at FLUSH.
        w_base = 16'd20; m_base = 16'd30; bias = 16'h0001;
        n_acc = 10'd2; n_pool = 4'd1; n_out = 10'd1;
        pulse_start();
        run_pass(100, -1, 0, 5);
        check("t4_hold_cycles", n_hold, 32'd5);
        check("t4_hold_stable", hold_err, 32'd0);
        check("t4_word_count", words.size(), 32'd1);
        if (words.size() == 1) check("t4_word", words[0], 32'h0000_0001);
        tick();

        // 33 neurons: two words, with weight and mean addresses wrapping at 2^16.
        w_base = 16'hFFFE; m_base = 16'hFFF0; bias = 16'hFEE0;
        n_acc = 10'd1; n_pool = 4'd1; n_out = 10'd33;
        pulse_start();
        run_pass(2000, -1, 0, 0);
        check("t5_word_count", words.size(), 32'd2);
        if (words.size() == 2) begin
            check("t5_word0", words[0], 32'h5555_5555);
            check("t5_word1", words[1], 32'h0000_0001);
        end
        check("t5_acc_count", acc_addr.size(), 32'd33);
        check("t5_norm_count", norm_addr.size(), 32'd33);
        if (acc_addr.size() == 33 && norm_addr.size() == 33) begin
            check("t5_acc_wrap", acc_addr[2], 32'd0);
            check("t5_acc_last", acc_addr[32], 32'd30);
            check("t5_norm_wrap", norm_addr[32], 32'h0000_0010);
        end
        check("t5_zero_fields", data_err + zero_err, 32'd0);
        tick();

        // Reset in the middle of ACC, then a fresh pass starts from neuron 0.
        w_base = 16'd0; m_base = 16'd0; bias = 16'd0;
        n_acc = 10'd8; n_pool = 4'd2; n_out = 10'd3;
        in_valid = 1'b1; out_ready = 1'b1;
        pulse_start();
        tick(); tick(); tick(); tick();
        check("t6_pre_reset_acc", 32'(com), 32'd1);
        reset = 1'b1;
        tick();
        check("t6_reset_com", {13'd0, com, addr}, {13'd0, 3'd7, 16'd0});
        check("t6_reset_flags", {29'd0, busy, out_valid, in_ready}, 32'd0);
        reset = 1'b0;
        tick();
        check("t6_idle_after", {31'd0, busy}, 32'd0);
        w_base = 16'd40; m_base = 16'd7; bias = 16'h0002;
        n_acc = 10'd2; n_pool = 4'd1; n_out = 10'd1;
        pulse_start();
        run_pass(100, -1, 0, 0);
        check("t6_acc_count", acc_addr.size(), 32'd2);
        if (acc_addr.size() == 2) check("t6_acc_addrs", {acc_addr[0][15:0], acc_addr[1][15:0]}, {16'd40, 16'd41});
        check("t6_norm_count", norm_addr.size(), 32'd1);
        if (norm_addr.size() == 1) check("t6_norm0", norm_addr[0], 32'd7);
        check("t6_word_count", words.size(), 32'd1);
        if (words.size() == 1) check("t6_word", words[0], 32'h0000_0001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
